// File: rtl/weight_stream_loader_if.sv
// weight_stream_loader_if: control, weight stream and memory write bundle for the loader
interface weight_stream_loader_if #(
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int N_DIM_ARRAY       = 4,
  parameter int ADDR_SIZE         = 14
);
  localparam int WW = WEIGHT_DATA_WIDTH * N_DIM_ARRAY;
  logic                         start;
  logic                         abort;
  logic [2:0]                   cfg_mode;
  logic [ADDR_SIZE-1:0]         cfg_base_addr;
  logic [ADDR_SIZE-1:0]         cfg_num_words;
  logic                         s_valid;
  logic [WEIGHT_DATA_WIDTH-1:0] s_data;
  logic                         s_ready;
  logic                         wr_en_ext_fc_w;
  logic [ADDR_SIZE-1:0]         wr_addr_ext_fc_w;
  logic [WW-1:0]                wr_data_ext_fc_w;
  logic                         wr_en_ext_cnn_w;
  logic [ADDR_SIZE-1:0]         wr_addr_ext_cnn_w;
  logic [WW-1:0]                wr_data_ext_cnn_w;
  logic                         busy;
  logic                         done;
  logic                         err;
  modport master (
    input  start, abort, cfg_mode, cfg_base_addr, cfg_num_words, s_valid, s_data,
    output s_ready, wr_en_ext_fc_w, wr_addr_ext_fc_w, wr_data_ext_fc_w,
           wr_en_ext_cnn_w, wr_addr_ext_cnn_w, wr_data_ext_cnn_w, busy, done, err
  );
  modport slave (
    output start, abort, cfg_mode, cfg_base_addr, cfg_num_words, s_valid, s_data,
    input  s_ready, wr_en_ext_fc_w, wr_addr_ext_fc_w, wr_data_ext_fc_w,
           wr_en_ext_cnn_w, wr_addr_ext_cnn_w, wr_data_ext_cnn_w, busy, done, err
  );
endinterface

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: packs a weight byte stream into words and writes them to the FC or CNN weight port
module weight_stream_loader #(
  parameter int WEIGHT_DATA_WIDTH = 8,
  parameter int N_DIM_ARRAY       = 4,
  parameter int ADDR_SIZE         = 14
) (
  input logic clk,
  input logic reset,
  weight_stream_loader_if.master bus
);
  localparam int WW = WEIGHT_DATA_WIDTH * N_DIM_ARRAY;
  localparam int LW = N_DIM_ARRAY > 1 ? $clog2(N_DIM_ARRAY) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t               state;
  logic                 cnn;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE-1:0] left;
  logic [LW-1:0]        lane;
  logic [WW-1:0]        word;
  logic [WW-1:0]        packed_w;
  logic [ADDR_SIZE:0]   end_addr;
  logic                 take;
  logic                 last_beat;
  // beat acceptance (abort wins) and the word as it looks with the current beat merged in
  always_comb begin
    end_addr = {1'b0, bus.cfg_base_addr} + {1'b0, bus.cfg_num_words};
    take = state == LOAD && bus.s_ready && bus.s_valid && !bus.abort;
    last_beat = take && lane == LW'(N_DIM_ARRAY - 1);
    packed_w = word;
    packed_w[lane*WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH] = bus.s_data;
  end
  // transfer FSM; s_ready dropping while in LOAD marks the final write as issued
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      cnn                   <= 1'b0;
      addr                  <= '0;
      left                  <= '0;
      lane                  <= '0;
      word                  <= '0;
      bus.s_ready           <= 1'b0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.err               <= 1'b0;
      bus.wr_en_ext_fc_w    <= 1'b0;
      bus.wr_addr_ext_fc_w  <= '0;
      bus.wr_data_ext_fc_w  <= '0;
      bus.wr_en_ext_cnn_w   <= 1'b0;
      bus.wr_addr_ext_cnn_w <= '0;
      bus.wr_data_ext_cnn_w <= '0;
    end else begin
      bus.done              <= 1'b0;
      bus.err               <= 1'b0;
      bus.wr_en_ext_fc_w    <= 1'b0;
      bus.wr_addr_ext_fc_w  <= '0;
      bus.wr_data_ext_fc_w  <= '0;
      bus.wr_en_ext_cnn_w   <= 1'b0;
      bus.wr_addr_ext_cnn_w <= '0;
      bus.wr_data_ext_cnn_w <= '0;
      case (state)
        IDLE: if (bus.start) begin
          if (bus.cfg_mode > 3'd1 || end_addr > {1'b1, {ADDR_SIZE{1'b0}}}) begin
            bus.err <= 1'b1;
          end else if (bus.cfg_num_words == '0) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b1;
          end else begin
            state       <= LOAD;
            bus.busy    <= 1'b1;
            bus.s_ready <= 1'b1;
            cnn         <= bus.cfg_mode[0];
            addr        <= bus.cfg_base_addr;
            left        <= bus.cfg_num_words;
            lane        <= '0;
          end
        end
        LOAD: if (bus.abort) begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.s_ready <= 1'b0;
          lane        <= '0;
        end else if (!bus.s_ready) begin
          state    <= DONE;
          bus.done <= 1'b1;
        end else if (take) begin
          word <= packed_w;
          lane <= last_beat ? '0 : lane + 1'b1;
          if (last_beat) begin
            bus.wr_en_ext_fc_w    <= !cnn;
            bus.wr_addr_ext_fc_w  <= cnn ? '0 : addr;
            bus.wr_data_ext_fc_w  <= cnn ? '0 : packed_w;
            bus.wr_en_ext_cnn_w   <= cnn;
            bus.wr_addr_ext_cnn_w <= cnn ? addr : '0;
            bus.wr_data_ext_cnn_w <= cnn ? packed_w : '0;
            addr                  <= addr + 1'b1;
            left                  <= left - 1'b1;
            bus.s_ready           <= left != ADDR_SIZE'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
